// File: rtl/md6_job_sequencer_pkg.sv
// md6_job_sequencer_pkg
//   Shared definitions for the MD6 job sequencer: state encoding (also
//   exported on state_dbg), default watchdog limits and counter width.
package md6_job_sequencer_pkg;

  localparam int unsigned SEQ_CNT_W       = 24;
  localparam logic [23:0] SEQ_TIMEOUT_DEF = 24'd10_000_000;
  localparam logic [19:0] SEQ_TX_DEF      = 20'd600_000;

  // Cycles the transmitter gets to raise tx_busy after tx_start.
  localparam int unsigned TX_START_WIN    = 4;

  // IDLE cycles during which done_rx is ignored after a retired job,
  // giving the receiver time to drop done_rx after rx_clear.
  localparam logic [1:0]  RETIRE_HOLDOFF  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HASH   = 3'd1,
    S_HOLD   = 3'd2,
    S_TX     = 3'd3,
    S_RETIRE = 3'd4,
    S_ERR    = 3'd5
  } seq_state_t;

  // States in which the MD6 core must stay enabled so D stays valid.
  function automatic logic job_holds_core(input seq_state_t s);
    return (s == S_HASH) || (s == S_HOLD) || (s == S_TX);
  endfunction

endpackage

// File: rtl/md6_job_sequencer_seq_watchdog.sv
// seq_watchdog
//   Saturating up-counter with synchronous clear and count enable. The
//   expire flag compares the current count against a caller-supplied last
//   value, so one instance serves both the hash and transmit limits.
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset (count -> 0)
//   i_clear   in   zero the count (wins over i_en)
//   i_en      in   increment the count, saturating at all-ones
//   i_last    in   count value that flags expiry
//   o_count   out  current count
//   o_expire  out  o_count == i_last
module seq_watchdog #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_last,
  output logic [CNT_W-1:0] o_count,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_count  = r_cnt;
  assign o_expire = (r_cnt == i_last);

endmodule

// File: rtl/md6_job_sequencer.sv
// md6_job_sequencer
//   Runs one MD6 job: arms the core when the receiver holds a full job,
//   waits for done_MD6 under a timeout, launches the UART transmit
//   (automatically or on a button pulse), supervises tx_busy, then clears
//   the receiver for the next job. All outputs are registered.
// Ports
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   done_rx      in   receiver holds a complete job
//   done_MD6     in   hash output valid (held while md6_enable is high)
//   tx_busy      in   transmitter shifting bytes
//   transmit_en  in   one-cycle debounced button pulse
//   auto_tx      in   1: transmit as soon as the hash is done
//   md6_enable   out  enable to MD6_Mode, high from arm until retire
//   tx_start     out  one-cycle transmit launch pulse
//   rx_clear     out  one-cycle receiver clear pulse
//   busy         out  sequencer not idle
//   err_timeout  out  sticky timeout flag, cleared by reset or new job
//   state_dbg    out  current state encoding
module md6_job_sequencer
  import md6_job_sequencer_pkg::*;
#(
  parameter logic [23:0]  TIMEOUT_CYCLES = SEQ_TIMEOUT_DEF,
  parameter logic [19:0]  TX_CYCLES      = SEQ_TX_DEF,
  parameter int unsigned  CNT_W          = SEQ_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       done_rx,
  input  logic       done_MD6,
  input  logic       tx_busy,
  input  logic       transmit_en,
  input  logic       auto_tx,
  output logic       md6_enable,
  output logic       tx_start,
  output logic       rx_clear,
  output logic       busy,
  output logic       err_timeout,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] LAST_HASH     = CNT_W'(TIMEOUT_CYCLES) - CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_TX       = CNT_W'(TX_CYCLES) - CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_TX_START = CNT_W'(TX_START_WIN - 1);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_last;
  logic             w_expire;
  logic             w_wd_en;
  logic             w_wd_clear;
  logic             r_tx_seen;
  logic [1:0]       r_holdoff;

  // The watchdog counts only in HASH and TX and restarts from zero on
  // every state change, so each phase measures from its own entry.
  assign w_wd_en    = (r_state == S_HASH) || (r_state == S_TX);
  assign w_wd_clear = (w_next != r_state) || !w_wd_en;
  assign w_last     = (r_state == S_TX) ? LAST_TX : LAST_HASH;

  seq_watchdog #(
    .CNT_W (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_wd_clear),
    .i_en     (w_wd_en),
    .i_last   (w_last),
    .o_count  (w_cnt),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if ((r_holdoff == '0) && done_rx) w_next = S_HASH;
      end
      S_HASH: begin
        // done_MD6 is checked before expiry so a tie completes the job.
        if (!done_rx)       w_next = S_RETIRE;
        else if (done_MD6)  w_next = auto_tx ? S_TX : S_HOLD;
        else if (w_expire)  w_next = S_ERR;
      end
      S_HOLD: begin
        if (transmit_en) w_next = S_TX;
      end
      S_TX: begin
        if (r_tx_seen && !tx_busy)
          w_next = S_RETIRE;
        else if (tx_busy && w_expire)
          w_next = S_ERR;
        else if (!r_tx_seen && !tx_busy && (w_cnt == LAST_TX_START))
          w_next = S_ERR;
      end
      S_RETIRE: w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered with it, so
  // each output changes on the same edge as the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      md6_enable  <= 1'b0;
      tx_start    <= 1'b0;
      rx_clear    <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      r_tx_seen   <= 1'b0;
      r_holdoff   <= '0;
    end else begin
      r_state    <= w_next;
      md6_enable <= job_holds_core(w_next);
      tx_start   <= (w_next == S_TX) && (r_state != S_TX);
      rx_clear   <= (w_next == S_RETIRE) || (w_next == S_ERR);
      busy       <= (w_next != S_IDLE);
      if (w_next == S_ERR)
        err_timeout <= 1'b1;
      else if ((w_next == S_HASH) && (r_state != S_HASH))
        err_timeout <= 1'b0;
      r_tx_seen  <= (r_state == S_TX) && (r_tx_seen || tx_busy);
      if (r_state == S_RETIRE)
        r_holdoff <= RETIRE_HOLDOFF;
      else if ((r_state == S_IDLE) && (r_holdoff != '0))
        r_holdoff <= r_holdoff - 2'd1;
    end
  end

  assign state_dbg = r_state;

endmodule

// File: tb/tb_md6_job_sequencer.sv
module tb_md6_job_sequencer;

  localparam int T_HASH = 64;
  localparam int T_TX   = 32;

  logic       clk = 1'b0;
  logic       reset, done_rx, done_MD6, tx_busy, transmit_en, auto_tx;
  logic       md6_enable, tx_start, rx_clear, busy, err_timeout;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  // Reference model: job phase (0..5 as exported on state_dbg), cycles
  // spent in the phase, TX busy-seen flag, post-retire quiet cycles.
  int m_phase, m_age, m_quiet;
  bit m_seen, m_err;

  md6_job_sequencer #(
    .TIMEOUT_CYCLES (24'd64),
    .TX_CYCLES      (20'd32),
    .CNT_W          (24)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .done_rx     (done_rx),
    .done_MD6    (done_MD6),
    .tx_busy     (tx_busy),
    .transmit_en (transmit_en),
    .auto_tx     (auto_tx),
    .md6_enable  (md6_enable),
    .tx_start    (tx_start),
    .rx_clear    (rx_clear),
    .busy        (busy),
    .err_timeout (err_timeout),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {state_dbg, md6_enable, tx_start, rx_clear, busy, err_timeout};
  endfunction

  function automatic logic [7:0] model_vec();
    logic en, ts, rc, bs;
    en = (m_phase >= 1) && (m_phase <= 3);
    ts = (m_phase == 3) && (m_age == 0);
    rc = (m_phase == 4) || (m_phase == 5);
    bs = (m_phase != 0);
    return {m_phase[2:0], en, ts, rc, bs, m_err};
  endfunction

  // Advance the model by one clock edge with the inputs currently driven.
  function automatic void model_step();
    int nxt;
    if (reset) begin
      m_phase = 0; m_age = 0; m_quiet = 0; m_seen = 0; m_err = 0;
      return;
    end
    nxt = m_phase;
    case (m_phase)
      0: if (m_quiet > 0) m_quiet--; else if (done_rx) nxt = 1;
      1: begin
        if (!done_rx)               nxt = 4;
        else if (done_MD6)          nxt = auto_tx ? 3 : 2;
        else if (m_age == T_HASH-1) nxt = 5;
      end
      2: if (transmit_en) nxt = 3;
      3: begin
        if (m_seen && !tx_busy)                     nxt = 4;
        else if (tx_busy && m_age == T_TX-1)        nxt = 5;
        else if (!m_seen && !tx_busy && m_age == 3) nxt = 5;
      end
      4: begin nxt = 0; m_quiet = 2; end
      default: nxt = 0;
    endcase
    if (m_phase == 3 && tx_busy) m_seen = 1;
    if (nxt != m_phase) begin
      m_age = 0;
      if (nxt == 3) m_seen = 0;
      if (nxt == 1) m_err = 0;
      if (nxt == 5) m_err = 1;
    end else begin
      m_age++;
    end
    m_phase = nxt;
  endfunction

  task automatic clk_step(input string name);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check(name, 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic do_reset();
    reset = 1'b1; done_rx = 1'b0; done_MD6 = 1'b0; tx_busy = 1'b0;
    transmit_en = 1'b0; auto_tx = 1'b0;
    clk_step("reset_model");
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [5:0] in;   // reset, done_rx, done_MD6, tx_busy, transmit_en, auto_tx
    logic [2:0] st;   // expected state_dbg
    logic [4:0] out;  // expected md6_enable, tx_start, rx_clear, busy, err_timeout
  } vec_t;

  vec_t tbl [16];

  initial begin
    int n, n_ts, bad;

    tbl[0]  = '{6'b100000, 3'd0, 5'b00000};
    tbl[1]  = '{6'b010000, 3'd1, 5'b10010};
    tbl[2]  = '{6'b010000, 3'd1, 5'b10010};
    tbl[3]  = '{6'b011000, 3'd2, 5'b10010};
    tbl[4]  = '{6'b011000, 3'd2, 5'b10010};
    tbl[5]  = '{6'b011010, 3'd3, 5'b11010};
    tbl[6]  = '{6'b011110, 3'd3, 5'b10010};
    tbl[7]  = '{6'b011100, 3'd3, 5'b10010};
    tbl[8]  = '{6'b011000, 3'd4, 5'b00110};
    tbl[9]  = '{6'b010000, 3'd0, 5'b00000};
    tbl[10] = '{6'b010000, 3'd0, 5'b00000};
    tbl[11] = '{6'b010000, 3'd0, 5'b00000};
    tbl[12] = '{6'b010000, 3'd1, 5'b10010};
    tbl[13] = '{6'b010000, 3'd1, 5'b10010};
    tbl[14] = '{6'b110000, 3'd0, 5'b00000};
    tbl[15] = '{6'b000000, 3'd0, 5'b00000};

    do_reset();
    check("reset_outputs", 32'(dut_vec()), 32'd0);

    // Table: manual flow, second transmit_en ignored, retire holdoff.
    for (int i = 0; i < 16; i++) begin
      {reset, done_rx, done_MD6, tx_busy, transmit_en, auto_tx} = tbl[i].in;
      clk_step("tbl_model");
      check($sformatf("tbl_row%0d", i), 32'(dut_vec()), 32'({tbl[i].st, tbl[i].out}));
    end

    // Nominal automatic transmit.
    do_reset();
    auto_tx = 1'b1; done_rx = 1'b1;
    clk_step("auto_arm");
    check("auto_enable", 32'(md6_enable), 32'd1);
    repeat (39) clk_step("auto_hash");
    done_MD6 = 1'b1;
    clk_step("auto_done");
    check("auto_txstart", 32'(tx_start), 32'd1);
    check("auto_state_tx", 32'(state_dbg), 32'd3);
    n_ts = 1;
    tx_busy = 1'b1;
    repeat (20) begin clk_step("auto_tx"); if (tx_start) n_ts++; end
    tx_busy = 1'b0;
    clk_step("auto_retire");
    check("auto_rx_clear", 32'({state_dbg, md6_enable, rx_clear}), 32'({3'd4, 1'b0, 1'b1}));
    done_rx = 1'b0; done_MD6 = 1'b0;
    clk_step("auto_idle");
    check("auto_idle", 32'({state_dbg, busy}), 32'd0);
    check("auto_one_pulse", 32'(n_ts), 32'd1);

    // Manual transmit with a long HOLD.
    do_reset();
    done_rx = 1'b1;
    repeat (6) clk_step("man_hash");
    done_MD6 = 1'b1;
    clk_step("man_done");
    check("man_hold", 32'(state_dbg), 32'd2);
    bad = 0;
    repeat (1000) begin
      clk_step("man_wait");
      if (!(md6_enable && state_dbg == 3'd2)) bad++;
    end
    check("hold_1000", 32'(bad), 32'd0);
    transmit_en = 1'b1;
    clk_step("man_press");
    transmit_en = 1'b0;
    n_ts = tx_start ? 1 : 0;
    tx_busy = 1'b1;
    clk_step("man_busy");
    if (tx_start) n_ts++;
    transmit_en = 1'b1;
    clk_step("man_press2");
    if (tx_start) n_ts++;
    transmit_en = 1'b0;
    repeat (5) begin clk_step("man_tx"); if (tx_start) n_ts++; end
    tx_busy = 1'b0;
    clk_step("man_retire");
    check("man_retire", 32'(state_dbg), 32'd4);
    check("man_one_pulse", 32'(n_ts), 32'd1);

    // Hash timeout, sticky error, cleared by next job, then abort.
    do_reset();
    done_rx = 1'b1;
    clk_step("to_arm");
    n = 0;
    while (state_dbg != 3'd5 && n < 200) begin clk_step("to_wait"); n++; end
    check("timeout_cycles", 32'(n), 32'd64);
    check("timeout_flags", 32'({err_timeout, md6_enable, rx_clear}), 32'({1'b1, 1'b0, 1'b1}));
    done_rx = 1'b0;
    repeat (3) clk_step("to_idle");
    check("err_sticky", 32'({state_dbg, err_timeout}), 32'({3'd0, 1'b1}));
    done_rx = 1'b1;
    clk_step("to_rearm");
    check("err_cleared", 32'({state_dbg, err_timeout}), 32'({3'd1, 1'b0}));
    done_rx = 1'b0;
    clk_step("abort");
    check("abort_retire", 32'({state_dbg, tx_start, rx_clear}), 32'({3'd4, 1'b0, 1'b1}));

    // done_MD6 on the expiry cycle.
    do_reset();
    done_rx = 1'b1;
    clk_step("tie_arm");
    repeat (63) clk_step("tie_wait");
    done_MD6 = 1'b1;
    clk_step("tie_done");
    check("tie_hold", 32'({state_dbg, err_timeout}), 32'({3'd2, 1'b0}));

    // tx_busy never rises.
    do_reset();
    auto_tx = 1'b1; done_rx = 1'b1;
    repeat (4) clk_step("stall_hash");
    done_MD6 = 1'b1;
    clk_step("stall_tx");
    n = 0;
    while (state_dbg != 3'd5 && n < 100) begin clk_step("stall_wait"); n++; end
    check("tx_nostart_cycles", 32'(n), 32'd4);

    // tx_busy stuck high.
    do_reset();
    auto_tx = 1'b1; done_rx = 1'b1;
    repeat (4) clk_step("stuck_hash");
    done_MD6 = 1'b1;
    clk_step("stuck_tx");
    tx_busy = 1'b1;
    n = 0;
    while (state_dbg != 3'd5 && n < 100) begin clk_step("stuck_wait"); n++; end
    check("tx_stuck_cycles", 32'(n), 32'd32);
    check("tx_stuck_err", 32'(err_timeout), 32'd1);

    // Reset in the middle of HASH with done_rx still high.
    do_reset();
    done_rx = 1'b1;
    repeat (11) clk_step("rst_hash");
    reset = 1'b1;
    clk_step("rst_mid");
    check("reset_mid", 32'(dut_vec()), 32'd0);
    reset = 1'b0;
    clk_step("rst_release");
    check("restart_after_reset", 32'({state_dbg, md6_enable}), 32'({3'd1, 1'b1}));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 23) == 0)  done_rx  = ~done_rx;
      if ($urandom_range(0, 11) == 0)  done_MD6 = ~done_MD6;
      if ($urandom_range(0, 5) == 0)   tx_busy  = ~tx_busy;
      if ($urandom_range(0, 99) == 0)  auto_tx  = ~auto_tx;
      transmit_en = ($urandom_range(0, 7) == 0);
      clk_step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
